sr_cmd_gen: RTL

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_cmd_pkg.sv | 20 ++
 rtl/sr_debounce.sv | 52 +++++
 rtl/sr_cmd_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command generator.
// Holds the pulse FSM states, command encoding and counter widths.
package sr_cmd_pkg;

    localparam int CNT_W = 8;
    localparam int DB_W  = 8;
    localparam int HO_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } sr_state_e;

    typedef enum logic {
        CMD_SET = 1'b0,
        CMD_CLR = 1'b1
    } sr_cmd_e;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, consecutive-cycle debounce filter and rise detector.
// Output rise is a registered one-cycle event on each 0->1 change of the filtered level.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            rise_r;

    // Synchronize the raw pin, then filter it and flag filtered rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            level_r  <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
            rise_r   <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            // Any cycle where the synchronized value agrees with the level restarts the count.
            if (sync2_r != level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    level_r  <= sync2_r;
                    db_cnt_r <= {DB_W{1'b0}};
                    rise_r   <= sync2_r;
                end else begin
                    db_cnt_r <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
                    rise_r   <= 1'b0;
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
                rise_r   <= 1'b0;
            end
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear request to one-cycle s/r pulse generator with holdoff.
// Optional build macro SR_CMD_GEN_SET_PRIORITY_EN: simultaneous set+clear issues s.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = 4,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_req_raw,
    input  logic             clr_req_raw,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             conflict,
    output logic [CNT_W-1:0] cmd_cnt
);

    localparam logic [HO_W-1:0] HO_INIT = HO_W'(HOLDOFF_CYCLES);
    localparam logic            HO_EN   = (HOLDOFF_CYCLES != 32'd0);

    logic             set_ev_s;
    logic             clr_ev_s;

    sr_state_e        state_r;
    sr_state_e        state_nx_s;
    sr_cmd_e          cmd_r;
    sr_cmd_e          cmd_nx_s;
    logic [HO_W-1:0]  ho_cnt_r;
    logic [HO_W-1:0]  ho_cnt_nx_s;
    logic             conflict_nx_s;

    logic             s_r;
    logic             r_r;
    logic             busy_r;
    logic             conflict_r;
    logic [CNT_W-1:0] cmd_cnt_r;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk   (clk),
        .reset (reset),
        .raw   (set_req_raw),
        .rise  (set_ev_s)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk   (clk),
        .reset (reset),
        .raw   (clr_req_raw),
        .rise  (clr_ev_s)
    );

    // Next-state logic; events outside IDLE are simply dropped.
    always_comb begin
        state_nx_s    = state_r;
        cmd_nx_s      = cmd_r;
        ho_cnt_nx_s   = ho_cnt_r;
        conflict_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (set_ev_s && clr_ev_s) begin
                    conflict_nx_s = 1'b1;
`ifdef SR_CMD_GEN_SET_PRIORITY_EN
                    state_nx_s = PULSE;
                    cmd_nx_s   = CMD_SET;
`else
                    state_nx_s = IDLE;
`endif
                end else if (set_ev_s) begin
                    state_nx_s = PULSE;
                    cmd_nx_s   = CMD_SET;
                end else if (clr_ev_s) begin
                    state_nx_s = PULSE;
                    cmd_nx_s   = CMD_CLR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PULSE: begin
                if (HO_EN) begin
                    state_nx_s  = HOLDOFF;
                    ho_cnt_nx_s = HO_INIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HOLDOFF: begin
                if (ho_cnt_r <= {{(HO_W-1){1'b0}}, 1'b1}) begin
                    state_nx_s  = IDLE;
                    ho_cnt_nx_s = {HO_W{1'b0}};
                end else begin
                    ho_cnt_nx_s = ho_cnt_r - {{(HO_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx_s  = IDLE;
                ho_cnt_nx_s = {HO_W{1'b0}};
            end
        endcase
    end

    // State register; outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cmd_r      <= CMD_SET;
            ho_cnt_r   <= {HO_W{1'b0}};
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
            cmd_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            cmd_r      <= cmd_nx_s;
            ho_cnt_r   <= ho_cnt_nx_s;
            s_r        <= (state_nx_s == PULSE) && (cmd_nx_s == CMD_SET);
            r_r        <= (state_nx_s == PULSE) && (cmd_nx_s == CMD_CLR);
            busy_r     <= (state_nx_s != IDLE);
            conflict_r <= conflict_nx_s;
            if (state_nx_s == PULSE) begin
                cmd_cnt_r <= cmd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cmd_cnt_r <= cmd_cnt_r;
            end
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign cmd_cnt  = cmd_cnt_r;

endmodule
